// File: rtl/axi_fifo_pkg.sv
// ---------------------------------------------------------------------------
// axi_fifo_pkg
//
// Shared definitions for the AXI master-side channel FIFOs.
//
// Contents:
//   - Bit positions of the packed AR word (ARBURST, ARSIZE, ARLEN, ARADDR,
//     ARID) and the resulting AR_W of 45 bits.
//   - Packed payload widths for the AW, W, R and B channels.
//   - ar_pkt_t, a packed struct whose layout matches the AR field positions.
//   - axi_chan_e and chanWidth(), which map a channel to its payload width
//     so that a FIFO instance can be sized per channel.
//
// Configuration macro used by the FIFO top level: AXI_FIFO_FLUSH_EN.
// ---------------------------------------------------------------------------
package axi_fifo_pkg;

    // Packed AR word field positions (LSB/MSB inclusive)
    localparam int AR_BURST_LSB = 0;
    localparam int AR_BURST_MSB = 1;
    localparam int AR_SIZE_LSB  = 2;
    localparam int AR_SIZE_MSB  = 4;
    localparam int AR_LEN_LSB   = 5;
    localparam int AR_LEN_MSB   = 8;
    localparam int AR_ADDR_LSB  = 9;
    localparam int AR_ADDR_MSB  = 40;
    localparam int AR_ID_LSB    = 41;
    localparam int AR_ID_MSB    = 44;

    // Packed payload widths per channel.
    // AW shares the AR layout; W is data(64)+strb(8)+last(1);
    // R is id(4)+data(64)+resp(2)+last(1); B is id(4)+resp(2).
    localparam int AR_W = 45;
    localparam int AW_W = 45;
    localparam int W_W  = 73;
    localparam int R_W  = 71;
    localparam int B_W  = 6;

    // Channel selector used when sizing a FIFO from the channel kind
    typedef enum logic [2:0] {
        CHAN_AR = 3'd0,
        CHAN_AW = 3'd1,
        CHAN_W  = 3'd2,
        CHAN_R  = 3'd3,
        CHAN_B  = 3'd4
    } axi_chan_e;

    // AR payload; member order gives ARID in the MSBs and ARBURST in the LSBs
    typedef struct packed {
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [3:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
    } ar_pkt_t;

    // Payload width of a given channel
    function automatic int chanWidth(input axi_chan_e chan);
        int width;
        width = AR_W;
        case (chan)
            CHAN_AR: width = AR_W;
            CHAN_AW: width = AW_W;
            CHAN_W:  width = W_W;
            CHAN_R:  width = R_W;
            CHAN_B:  width = B_W;
            default: width = AR_W;
        endcase
        return width;
    endfunction

endpackage

// File: rtl/axi_fifo_ptr.sv
// ---------------------------------------------------------------------------
// axi_fifo_ptr
//
// One FIFO pointer: ADDR_W index bits plus a wrap bit in the MSB. The pointer
// increments on inc_i and wraps naturally; load_i overrides the increment
// and replaces the pointer with loadVal_i. The pointer is compared with the
// opposite side's pointer to produce one status flag:
//   CMP_FULL = 1 : flag_o = index equal and wrap bits differ (full)
//   CMP_FULL = 0 : flag_o = pointers fully equal             (empty)
//
// Ports:
//   clk         clock
//   rst         synchronous active-low reset, clears the pointer
//   inc_i       advance the pointer by one
//   load_i      replace the pointer with loadVal_i (wins over inc_i)
//   loadVal_i   value loaded when load_i is high
//   otherPtr_i  the opposite side's pointer
//   ptr_o       current registered pointer
//   flag_o      full or empty compare result, see CMP_FULL
// ---------------------------------------------------------------------------
module axi_fifo_ptr
    import axi_fifo_pkg::*;
#(
    parameter int ADDR_W   = 2,
    parameter bit CMP_FULL = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_i,
    input  logic            load_i,
    input  logic [ADDR_W:0] loadVal_i,
    input  logic [ADDR_W:0] otherPtr_i,
    output logic [ADDR_W:0] ptr_o,
    output logic            flag_o
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] ptr_q;
    logic [ADDR_W:0] ptr_d;
    logic            sameIdx;
    logic            wrapDiff;

    // Next pointer: a load replaces the value outright, otherwise a single
    // increment whose carry out of the index bits lands in the wrap bit.
    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = loadVal_i;
        end else if (inc_i) begin
            ptr_d = ptr_q + PTR_ONE;
        end
    end

    // Pointer register, cleared by the synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Equal indices mean either empty or full; the wrap bit tells which.
    assign sameIdx  = (ptr_q[ADDR_W-1:0] == otherPtr_i[ADDR_W-1:0]);
    assign wrapDiff = (ptr_q[ADDR_W] != otherPtr_i[ADDR_W]);
    assign flag_o   = CMP_FULL ? (sameIdx & wrapDiff) : (sameIdx & ~wrapDiff);
    assign ptr_o    = ptr_q;

endmodule

// File: rtl/axi_chan_fifo.sv
// ---------------------------------------------------------------------------
// axi_chan_fifo
//
// Single-clock first-word-fall-through FIFO for one AXI master-side channel
// (AR/AW/W/R/B). Data written at one edge is visible on rdata right after
// that edge. Occupancy, a programmable almost-full and sticky overflow and
// underflow flags are provided.
//
// Parameters:
//   DATA_W    payload width (default AR_W = 45, the packed AR word)
//   DEPTH     number of entries, power of two, >= 2
//   AFULL_TH  almost_full asserts when count >= AFULL_TH, range 1..DEPTH
//
// Ports:
//   clk          clock
//   rst          synchronous active-low reset
//   wpush        write request, dropped while full
//   wdata        write payload
//   wfull        no free entry
//   almost_full  count >= AFULL_TH
//   rpop         read request, consumes the head entry, ignored while empty
//   rdata        head entry, zero while empty
//   rempty       no valid entry
//   count        occupancy 0..DEPTH
//   ovf          sticky: push attempted while full
//   udf          sticky: pop attempted while empty
//   flush        only with AXI_FIFO_FLUSH_EN: discard all entries,
//                including a push in the same cycle
//
// Configuration macro: AXI_FIFO_FLUSH_EN adds the flush input.
// ---------------------------------------------------------------------------
module axi_chan_fifo
    import axi_fifo_pkg::*;
#(
    parameter int DATA_W   = AR_W,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = DEPTH - 1,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int CNT_W   = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wpush,
    input  logic [DATA_W-1:0] wdata,
    output logic              wfull,
    output logic              almost_full,
    input  logic              rpop,
    output logic [DATA_W-1:0] rdata,
    output logic              rempty,
    output logic [CNT_W-1:0]  count,
    output logic              ovf,
`ifdef AXI_FIFO_FLUSH_EN
    output logic              udf,
    input  logic              flush
`else
    output logic              udf
`endif
);

    localparam logic [ADDR_W:0]  PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_TH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W:0] wPtr;
    logic [ADDR_W:0] rPtr;
    logic            fullFlag;
    logic            emptyFlag;
    logic            wen;
    logic            ren;
    logic            rdLoad;
    logic [ADDR_W:0] rdLoadVal;

    logic ovf_q;
    logic ovf_d;
    logic udf_q;
    logic udf_d;

    // Full is judged before any pop, so a full FIFO never writes through.
    assign wen = wpush & ~fullFlag;
    assign ren = rpop & ~emptyFlag;

`ifdef AXI_FIFO_FLUSH_EN
    // Flush jumps the read pointer to where the write pointer will be after
    // this edge, which also discards a push accepted in the same cycle.
    assign rdLoad    = flush;
    assign rdLoadVal = wen ? (wPtr + PTR_ONE) : wPtr;
`else
    assign rdLoad    = 1'b0;
    assign rdLoadVal = '0;
`endif

    axi_fifo_ptr #(
        .ADDR_W   (ADDR_W),
        .CMP_FULL (1'b1)
    ) u_wrPtr (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (wen),
        .load_i     (1'b0),
        .loadVal_i  ('0),
        .otherPtr_i (rPtr),
        .ptr_o      (wPtr),
        .flag_o     (fullFlag)
    );

    axi_fifo_ptr #(
        .ADDR_W   (ADDR_W),
        .CMP_FULL (1'b0)
    ) u_rdPtr (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (ren),
        .load_i     (rdLoad),
        .loadVal_i  (rdLoadVal),
        .otherPtr_i (wPtr),
        .ptr_o      (rPtr),
        .flag_o     (emptyFlag)
    );

    // Register file write. Storage is not reset; stale entries stay hidden
    // because the pointers clear and rempty masks rdata.
    always_ff @(posedge clk) begin
        if (rst && wen) begin
            mem_q[wPtr[ADDR_W-1:0]] <= wdata;
        end
    end

    // Sticky error flags collect illegal requests until reset.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (wpush && fullFlag) begin
            ovf_d = 1'b1;
        end
        if (rpop && emptyFlag) begin
            udf_d = 1'b1;
        end
    end

    // Sticky flag registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Occupancy is the modular pointer difference; the wrap bit makes
    // DEPTH representable alongside 0.
    assign count       = wPtr - rPtr;
    assign almost_full = (count >= AFULL_CNT);
    assign wfull       = fullFlag;
    assign rempty      = emptyFlag;
    assign rdata       = emptyFlag ? '0 : mem_q[rPtr[ADDR_W-1:0]];
    assign ovf         = ovf_q;
    assign udf         = udf_q;

endmodule

// File: tb/tb_axi_chan_fifo.sv
// ---------------------------------------------------------------------------
// tb_axi_chan_fifo
//
// Drives axi_chan_fifo (DATA_W=45, DEPTH=4, AFULL_TH=3) through directed
// fill/drain, full, wrap, empty-pop and reset scenarios followed by a random
// phase, comparing every output each cycle against a queue-based model.
// Build with AXI_FIFO_FLUSH_EN defined to include the flush scenarios.
// ---------------------------------------------------------------------------
module tb_axi_chan_fifo;

    localparam int DATA_W   = 45;
    localparam int DEPTH    = 4;
    localparam int AFULL_TH = 3;
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              wpush;
    logic [DATA_W-1:0] wdata;
    logic              wfull;
    logic              almost_full;
    logic              rpop;
    logic [DATA_W-1:0] rdata;
    logic              rempty;
    logic [CNT_W-1:0]  count;
    logic              ovf;
    logic              udf;
    logic              flush;

    // Reference model: the FIFO contents as a plain queue plus sticky bits
    logic [DATA_W-1:0] modelQ[$];
    bit                modelOvf;
    bit                modelUdf;

    int checkCount;
    int passCount;

    axi_chan_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wpush       (wpush),
        .wdata       (wdata),
        .wfull       (wfull),
        .almost_full (almost_full),
        .rpop        (rpop),
        .rdata       (rdata),
        .rempty      (rempty),
        .count       (count),
        .ovf         (ovf),
`ifdef AXI_FIFO_FLUSH_EN
        .udf         (udf),
        .flush       (flush)
`else
        .udf         (udf)
`endif
    );

    // 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Compare every DUT output against the model's current state
    task automatic checkAll(input string tag);
        int n;
        logic [DATA_W-1:0] head;
        n    = modelQ.size();
        head = (n > 0) ? modelQ[0] : '0;
        checkOutput({tag, ".count"},  64'(count),       64'(n));
        checkOutput({tag, ".rempty"}, 64'(rempty),      64'(n == 0));
        checkOutput({tag, ".wfull"},  64'(wfull),       64'(n == DEPTH));
        checkOutput({tag, ".afull"},  64'(almost_full), 64'(n >= AFULL_TH));
        checkOutput({tag, ".rdata"},  64'(rdata),       64'(head));
        checkOutput({tag, ".ovf"},    64'(ovf),         64'(modelOvf));
        checkOutput({tag, ".udf"},    64'(udf),         64'(modelUdf));
    endtask

    // One clock of stimulus: drive on the falling edge, let the rising edge
    // act, advance the model by the same request, then check all outputs.
    task automatic applyStimulus(input string tag, input bit push,
                                 input logic [DATA_W-1:0] data, input bit pop,
                                 input bit rstN, input bit fl);
        bit wasFull;
        bit wasEmpty;
        @(negedge clk);
        wpush = push;
        wdata = data;
        rpop  = pop;
        rst   = rstN;
        flush = fl;
        @(posedge clk);
        #1;
        wasFull  = (modelQ.size() == DEPTH);
        wasEmpty = (modelQ.size() == 0);
        if (!rstN) begin
            modelQ.delete();
            modelOvf = 1'b0;
            modelUdf = 1'b0;
        end else begin
            if (push && wasFull) modelOvf = 1'b1;
            if (pop && wasEmpty) modelUdf = 1'b1;
`ifdef AXI_FIFO_FLUSH_EN
            if (fl) begin
                modelQ.delete();
            end else begin
`else
            begin
`endif
                if (pop && !wasEmpty) void'(modelQ.pop_front());
                if (push && !wasFull) modelQ.push_back(data);
            end
        end
        checkAll(tag);
    endtask

    initial begin
        logic [DATA_W-1:0] rnd;
        checkCount = 0;
        passCount  = 0;
        modelOvf   = 1'b0;
        modelUdf   = 1'b0;
        rst   = 1'b0;
        wpush = 1'b0;
        wdata = '0;
        rpop  = 1'b0;
        flush = 1'b0;

        // Reset then idle
        applyStimulus("reset0", 0, '0, 0, 0, 0);
        applyStimulus("reset1", 0, '0, 0, 0, 0);
        applyStimulus("idle",   0, '0, 0, 1, 0);

        // Fill with 1..4, then drain in order
        for (int i = 1; i <= 4; i++) applyStimulus("fill", 1, DATA_W'(i), 0, 1, 0);
        checkOutput("fillCount", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) applyStimulus("drain", 0, '0, 1, 1, 0);
        checkOutput("drainEmpty", 64'(rempty), 64'd1);

        // Full boundary: push 5 with a pop while full; 5 must be dropped
        for (int i = 1; i <= 4; i++) applyStimulus("refill", 1, DATA_W'(i), 0, 1, 0);
        checkOutput("fullHead", 64'(rdata), 64'd1);
        applyStimulus("fullPushPop", 1, DATA_W'(5), 1, 1, 0);
        checkOutput("fullOvf", 64'(ovf), 64'd1);
        checkOutput("fullCount", 64'(count), 64'd3);
        checkOutput("fullNewHead", 64'(rdata), 64'd2);
        for (int i = 0; i < 3; i++) applyStimulus("fullDrain", 0, '0, 1, 1, 0);

        // Wrap-around with push/pop pairs at occupancy one
        applyStimulus("wrapFirst", 1, DATA_W'(45'h100), 0, 1, 0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus("wrapPair", 1, DATA_W'(45'h100 + i), 1, 1, 0);
            checkOutput("wrapData", 64'(rdata), 64'(45'h100 + i));
        end
        applyStimulus("wrapLast", 0, '0, 1, 1, 0);

        // Empty pop, then reset with entries present
        applyStimulus("emptyPop", 0, '0, 1, 1, 0);
        checkOutput("emptyUdf", 64'(udf), 64'd1);
        applyStimulus("prePush0", 1, DATA_W'(45'h77), 0, 1, 0);
        applyStimulus("prePush1", 1, DATA_W'(45'h78), 0, 1, 0);
        applyStimulus("midReset", 1, DATA_W'(45'h79), 0, 0, 0);
        checkOutput("midResetCount", 64'(count), 64'd0);
        applyStimulus("postReset", 0, '0, 0, 1, 0);

`ifdef AXI_FIFO_FLUSH_EN
        // Flush together with a push: everything including 0xA is discarded
        for (int i = 1; i <= 3; i++) applyStimulus("flFill", 1, DATA_W'(45'h20 + i), 0, 1, 0);
        applyStimulus("flush", 1, DATA_W'(45'hA), 0, 1, 1);
        checkOutput("flushEmpty", 64'(rempty), 64'd1);
        applyStimulus("flushPop", 0, '0, 1, 1, 0);
        applyStimulus("flushPush", 1, DATA_W'(45'hB), 0, 1, 0);
        checkOutput("flushHead", 64'(rdata), 64'hB);
        applyStimulus("flushDrain", 0, '0, 1, 1, 0);
`endif

        // Random phase with occasional reset (and flush when built in)
        for (int i = 0; i < 400; i++) begin
            rnd = DATA_W'({$urandom, $urandom});
            applyStimulus("random", $urandom_range(0, 99) < 55, rnd,
                          $urandom_range(0, 99) < 50,
                          $urandom_range(0, 99) >= 2,
                          $urandom_range(0, 99) < 3);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
